pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_ctrl.sv | 141 ++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl -- PWM generator with a linear duty-cycle fader.
//
// A free-running counter cnt sweeps 0..PERIOD (one PWM period = PERIOD+1
// cycles). pwm_out is high while cnt < duty_cur. A start request captures a
// target duty (clamped to PERIOD+1) and the FSM walks duty_cur one LSB toward
// it every HOLD periods, always at a period boundary.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en           count enable; 0 freezes cnt, hold_cnt and the fade
//   clr          synchronous abort: cnt/hold_cnt cleared, FSM to IDLE,
//                duty_cur kept, no done pulse; overrides start and en
//   start        fade request, honoured only in IDLE
//   target       requested final duty (DW bits)
//   pwm_out      registered PWM waveform
//   duty_cur     duty currently applied
//   busy         high while a fade is running
//   done         one-cycle pulse when a fade completes (or is a null fade)
//   period_tick  high in the cycle where cnt==PERIOD and en==1
module pwm_fade_ctrl #(
  parameter int unsigned PERIOD = 7,
  parameter int unsigned DW     = 4,
  parameter int unsigned HOLD   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          start,
  input  logic [DW-1:0] target,
  output logic          pwm_out,
  output logic [DW-1:0] duty_cur,
  output logic          busy,
  output logic          done,
  output logic          period_tick
);

  localparam int unsigned   HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW-1:0] MAX_DUTY  = DW'(PERIOD + 1);
  localparam logic [DW-1:0] CNT_LAST  = DW'(PERIOD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic {
    IDLE,
    RAMP
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] tgt;
  logic [HW-1:0] hold_cnt;

  logic [DW-1:0] cnt_nxt;
  logic [DW-1:0] duty_nxt;
  logic [DW-1:0] tgt_cap;
  logic          tick;
  logic          step;

  assign tick        = en && (cnt == CNT_LAST);
  assign period_tick = tick;

  // Requests above full-on are clamped rather than wrapped.
  assign tgt_cap = (target > MAX_DUTY) ? MAX_DUTY : target;

  // Next-state counter and duty are computed here so that pwm_out can be
  // registered from them and stay cycle-aligned with cnt/duty_cur.
  always_comb begin
    cnt_nxt  = cnt;
    duty_nxt = duty_cur;
    step     = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
    // Steps happen only on the period's last cycle, so the new duty applies
    // from cnt=0 onward. In RAMP duty_cur != tgt, so the step never overshoots.
    if (!clr && (state == RAMP) && tick && (hold_cnt == HOLD_LAST)) begin
      step     = 1'b1;
      duty_nxt = (duty_cur < tgt) ? duty_cur + 1'b1 : duty_cur - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_cnt <= '0;
      duty_cur <= '0;
      tgt      <= '0;
      pwm_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      duty_cur <= duty_nxt;
      pwm_out  <= (cnt_nxt < duty_nxt);
      done     <= 1'b0;
      if (clr) begin
        state    <= IDLE;
        hold_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              tgt      <= tgt_cap;
              hold_cnt <= '0;
              if (tgt_cap != duty_cur) begin
                state <= RAMP;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RAMP: begin
            if (tick) begin
              if (step) begin
                hold_cnt <= '0;
                if (duty_nxt == tgt) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with PERIOD=7, DW=4, HOLD=2.
// Every fade is preceded by a clr pulse so cnt starts at 0; with start applied
// on the following cycle the first step lands 15 edges after the start edge
// and later steps every 16 edges.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       start;
  logic [3:0] target;
  logic       pwm_out;
  logic [3:0] duty_cur;
  logic       busy;
  logic       done;
  logic       period_tick;

  int n_checks = 0;
  int n_fail   = 0;

  int r_steps, r_first, r_last, r_done, r_done_k, r_busy, r_bad;

  pwm_fade_ctrl #(
    .PERIOD (7),
    .DW     (4),
    .HOLD   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clr         (clr),
    .start       (start),
    .target      (target),
    .pwm_out     (pwm_out),
    .duty_cur    (duty_cur),
    .busy        (busy),
    .done        (done),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Count pwm_out high cycles over one full period.
  task automatic count_high(output int n);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pwm_out) n++;
    end
  endtask

  // Runs one fade from an aligned counter. Observation k is taken at the
  // negedge after edge k, edge 0 being the one that samples start.
  // Optional events (disabled with -1): a second start at restart_at, an
  // en=0 window of pause_len cycles after pause_at, a clr at clr_at.
  task automatic run_fade(input logic [3:0] tgt_in, input int max_k,
                          input int restart_at, input logic [3:0] restart_tgt,
                          input int pause_at, input int pause_len,
                          input int clr_at);
    logic [3:0] prev_duty, frz_duty;
    logic       prev_tick, frz_pwm;
    clr = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    start     = 1'b1;
    target    = tgt_in;
    prev_duty = duty_cur;
    prev_tick = period_tick;
    frz_duty  = '0;
    frz_pwm   = 1'b0;
    r_steps = 0; r_first = -1; r_last = -1; r_done = 0;
    r_done_k = -1; r_busy = 0; r_bad = 0;
    for (int k = 0; k <= max_k; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (duty_cur != prev_duty) begin
        r_steps++;
        if (r_first < 0) r_first = k;
        r_last = k;
        if (!prev_tick) r_bad++;
      end
      if (busy) r_busy++;
      if (done) begin
        r_done++;
        r_done_k = k;
        if (busy) r_bad++;
      end
      if (pause_at >= 0 && k > pause_at && k <= pause_at + pause_len &&
          (duty_cur != frz_duty || pwm_out != frz_pwm || period_tick))
        r_bad++;
      prev_duty = duty_cur;
      prev_tick = period_tick;
      if (restart_at >= 0 && k == restart_at) begin
        start  = 1'b1;
        target = restart_tgt;
      end else if (restart_at >= 0 && k == restart_at + 1) begin
        start  = 1'b0;
        target = tgt_in;
      end
      if (pause_at >= 0 && k == pause_at) begin
        en       = 1'b0;
        frz_duty = duty_cur;
        frz_pwm  = pwm_out;
      end
      if (pause_at >= 0 && k == pause_at + pause_len) en = 1'b1;
      clr = (clr_at >= 0 && k == clr_at);
      if (done) break;
    end
    clr = 1'b0;
  endtask

  initial begin
    int n_hi;
    int n_done;
    rst    = 1'b1;
    en     = 1'b1;
    clr    = 1'b0;
    start  = 1'b0;
    target = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm",   pwm_out,     0);
    check("rst_duty",  duty_cur,    0);
    check("rst_busy",  busy,        0);
    check("rst_done",  done,        0);
    check("rst_ptick", period_tick, 0);
    rst = 1'b0;
    // After release cnt counts 1,2,..; tick on the cycle where cnt==7.
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      check("ptick_cadence", period_tick, (i % 8 == 7) ? 1 : 0);
    end

    // Fade up 0 -> 4
    run_fade(4'd4, 200, -1, 4'd0, -1, 0, -1);
    check("up_steps", r_steps, 4);
    check("up_first", r_first, 15);
    check("up_last",  r_last,  63);
    check("up_done",  r_done,  1);
    check("up_donek", r_done_k, 63);
    check("up_busy",  r_busy,  63);
    check("up_bad",   r_bad,   0);
    check("up_duty",  duty_cur, 4);
    count_high(n_hi);
    check("up_pwm_hi", n_hi, 4);

    // Clamp: 15 -> 8, ends constant high
    run_fade(4'd15, 200, -1, 4'd0, -1, 0, -1);
    check("clamp_steps", r_steps, 4);
    check("clamp_last",  r_last,  63);
    check("clamp_done",  r_done,  1);
    check("clamp_duty",  duty_cur, 8);
    count_high(n_hi);
    check("clamp_pwm_hi", n_hi, 8);

    // Fade down 8 -> 0, ends constant low
    run_fade(4'd0, 300, -1, 4'd0, -1, 0, -1);
    check("down_steps", r_steps, 8);
    check("down_first", r_first, 15);
    check("down_last",  r_last,  127);
    check("down_done",  r_done,  1);
    check("down_busy",  r_busy,  127);
    check("down_bad",   r_bad,   0);
    check("down_duty",  duty_cur, 0);
    count_high(n_hi);
    check("down_pwm_hi", n_hi, 0);

    // Null fade: target equals duty_cur
    run_fade(4'd0, 20, -1, 4'd0, -1, 0, -1);
    check("null_done",  r_done,   1);
    check("null_donek", r_done_k, 0);
    check("null_busy",  r_busy,   0);
    check("null_bad",   r_bad,    0);

    // Start during RAMP is ignored: 0 -> 3, second start to 6 at k=20
    run_fade(4'd3, 200, 20, 4'd6, -1, 0, -1);
    check("ign_steps", r_steps, 3);
    check("ign_last",  r_last,  47);
    check("ign_done",  r_done,  1);
    check("ign_duty",  duty_cur, 3);

    // Pause 20 cycles mid-ramp: 3 -> 5, completion delayed by 20
    run_fade(4'd5, 200, -1, 4'd0, 10, 20, -1);
    check("pause_steps", r_steps, 2);
    check("pause_first", r_first, 35);
    check("pause_last",  r_last,  51);
    check("pause_done",  r_done,  1);
    check("pause_busy",  r_busy,  51);
    check("pause_bad",   r_bad,   0);
    check("pause_duty",  duty_cur, 5);

    // clr abort: 5 -> 1, clr after the first step
    run_fade(4'd1, 100, -1, 4'd0, -1, 0, 20);
    check("abort_steps", r_steps, 1);
    check("abort_first", r_first, 15);
    check("abort_done",  r_done,  0);
    check("abort_busy",  r_busy,  21);
    check("abort_duty",  duty_cur, 4);

    // Async reset mid-cycle during a ramp 4 -> 8
    clr = 1'b1;
    @(negedge clk);
    clr    = 1'b0;
    start  = 1'b1;
    target = 4'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_pwm",   pwm_out,     0);
    check("arst_duty",  duty_cur,    0);
    check("arst_busy",  busy,        0);
    check("arst_done",  done,        0);
    check("arst_ptick", period_tick, 0);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("post_rst_duty", duty_cur, 0);
    check("post_rst_busy", busy,     0);
    check("post_rst_pwm",  pwm_out,  0);
    check("post_rst_done", n_done,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
